// File: rtl/freq_div_checker.sv
// rtl/freq_div_checker.sv - measures period/high time of a divided clock in half-cycles and checks ratio, duty and lock
//
// Purpose
//   clk_div is sampled on both edges of clk_in, producing a half-cycle sample
//   stream. Rising steps in that stream delimit periods; each completed period
//   is reported in half-cycles, together with its high time, and is checked
//   against an exact DIV_N ratio at 50% duty. A run of LOCK_CNT good periods
//   asserts locked. A period that runs to 4*DIV_N half-cycles without a rise
//   is reported as a timeout.
//
// Parameters
//   DIV_N     expected divide ratio of clk_div against clk_in (2..63)
//   LOCK_CNT  consecutive good periods needed for locked (1..15)
//   CNT_W     width of the half-cycle counters; 2**CNT_W must exceed 4*DIV_N
//
// Ports
//   clk_in      in   1      reference clock
//   reset       in   1      synchronous, active-high
//   clk_div     in   1      divided clock under test, synchronous to clk_in
//   period_hc   out  CNT_W  last completed period, clk_in half-cycles
//   high_hc     out  CNT_W  high time of that period, clk_in half-cycles
//   meas_valid  out  1      one-cycle pulse when period_hc/high_hc update
//   locked      out  1      ratio and duty confirmed
//   err         out  1      one-cycle pulse on a bad period or a timeout
//   err_count   out  8      saturating count of err pulses

module freq_div_checker #(
    parameter int DIV_N    = 3,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             clk_div,
    output logic [CNT_W-1:0] period_hc,
    output logic [CNT_W-1:0] high_hc,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_count
);

    localparam logic [CNT_W-1:0] GOOD_PERIOD = CNT_W'(2 * DIV_N);
    localparam logic [CNT_W-1:0] GOOD_HIGH   = CNT_W'(DIV_N);
    localparam logic [CNT_W:0]   TIMEOUT_HC  = (CNT_W + 1)'(4 * DIV_N);
    localparam logic [3:0]       LOCK_TGT    = 4'(LOCK_CNT);
    localparam logic [CNT_W-1:0] ONE_HC      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_HC      = CNT_W'(2);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Sampling
    logic             s_neg;
    logic             prev;

    // Half-cycle measurement counters of the period in progress
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] per_nxt;
    logic [CNT_W-1:0] high_nxt;

    // Pair evaluation
    logic             rise_a;
    logic             rise_b;
    logic             rise;
    logic [CNT_W:0]   per_acc;
    logic [CNT_W-1:0] high_acc;
    logic [CNT_W-1:0] close_period;
    logic             close_good;
    logic             meas_fire;
    logic             timeout_fire;

    // Result stage between pair processing and the registered outputs
    logic             pend_meas;
    logic             pend_timeout;
    logic             pend_good;
    logic [CNT_W-1:0] pend_period;
    logic [CNT_W-1:0] pend_high;

    // Lock tracking
    logic [3:0]       good_run;
    logic [3:0]       good_inc;
    logic             err_nxt;

    // ------------------------------------------------------------------
    // Negedge sampler: the first sample of each pair. clk_div changes
    // synchronously to clk_in, so the value captured here is the one it
    // held just before this falling edge.
    // ------------------------------------------------------------------
    always_ff @(negedge clk_in) begin
        if (reset) begin
            s_neg <= 1'b0;
        end else begin
            s_neg <= clk_div;
        end
    end

    // ------------------------------------------------------------------
    // Pair evaluation. The pair is (s_neg, clk_div) where clk_div is the
    // value seen at this rising edge; prev is the second sample of the
    // previous pair. Two 0->1 steps cannot fit in one pair, so at most
    // one of rise_a / rise_b is set.
    // ------------------------------------------------------------------
    assign rise_a = !prev && s_neg;
    assign rise_b = !s_neg && clk_div;
    assign rise   = rise_a || rise_b;

    // Counts after absorbing both samples of a pair that has no rise.
    // per_acc is one bit wider so the timeout compare cannot alias.
    assign per_acc  = {1'b0, per_cnt} + (CNT_W + 1)'(2);
    assign high_acc = high_cnt + CNT_W'(s_neg) + CNT_W'(clk_div);

    // Closing period: a rise on the first sample closes the period before
    // that sample; a rise on the second sample also includes s_neg, which
    // is 0 by definition of that rise, so the high count is unchanged in
    // both cases.
    assign close_period = rise_a ? per_cnt : (per_cnt + ONE_HC);
    assign close_good   = (close_period == GOOD_PERIOD) && (high_cnt == GOOD_HIGH);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        per_nxt      = per_cnt;
        high_nxt     = high_cnt;
        meas_fire    = 1'b0;
        timeout_fire = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MEAS;
                end else begin
                    per_nxt  = '0;
                    high_nxt = '0;
                end
            end
            MEAS: begin
                if (rise) begin
                    meas_fire = 1'b1;
                end else if (per_acc >= TIMEOUT_HC) begin
                    timeout_fire = 1'b1;
                    state_nxt    = IDLE;
                    per_nxt      = '0;
                    high_nxt     = '0;
                end else begin
                    per_nxt  = per_acc[CNT_W-1:0];
                    high_nxt = high_acc;
                end
            end
            default: begin
                state_nxt = IDLE;
                per_nxt   = '0;
                high_nxt  = '0;
            end
        endcase

        // Any rise starts a new period at the rise sample, whether it came
        // from IDLE or closed a period in MEAS. A first-sample rise puts
        // both samples of the pair into the new period; a second-sample
        // rise puts only the (high) rise sample there.
        if (rise) begin
            per_nxt  = rise_a ? TWO_HC : ONE_HC;
            high_nxt = rise_a ? (ONE_HC + CNT_W'(clk_div)) : ONE_HC;
        end
    end

    // ------------------------------------------------------------------
    // Counters, previous sample and result stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset) begin
            prev         <= 1'b0;
            per_cnt      <= '0;
            high_cnt     <= '0;
            pend_meas    <= 1'b0;
            pend_timeout <= 1'b0;
            pend_good    <= 1'b0;
            pend_period  <= '0;
            pend_high    <= '0;
        end else begin
            prev         <= clk_div;
            per_cnt      <= per_nxt;
            high_cnt     <= high_nxt;
            pend_meas    <= meas_fire;
            pend_timeout <= timeout_fire;
            pend_good    <= close_good;
            pend_period  <= close_period;
            pend_high    <= high_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and lock tracking
    // ------------------------------------------------------------------
    assign err_nxt  = (pend_meas && !pend_good) || pend_timeout;
    assign good_inc = good_run + 4'd1;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            period_hc  <= '0;
            high_hc    <= '0;
            meas_valid <= 1'b0;
            err        <= 1'b0;
            locked     <= 1'b0;
            good_run   <= 4'd0;
            err_count  <= 8'd0;
        end else begin
            meas_valid <= pend_meas;
            err        <= err_nxt;

            if (pend_meas) begin
                period_hc <= pend_period;
                high_hc   <= pend_high;
            end

            if (err_nxt) begin
                good_run <= 4'd0;
                locked   <= 1'b0;
            end else if (pend_meas) begin
                // The run counter parks at the lock target; locked is then
                // held until the next bad period or timeout.
                if (good_run != LOCK_TGT) begin
                    good_run <= good_inc;
                end
                if (good_inc == LOCK_TGT) begin
                    locked <= 1'b1;
                end
            end

            if (err_nxt && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_freq_div_checker.sv
// tb/tb_freq_div_checker.sv - self-checking bench for freq_div_checker against a half-cycle stream model

module tb_freq_div_checker;

    localparam int DIV_N    = 3;
    localparam int LOCK_CNT = 4;
    localparam int CNT_W    = 8;

    logic             clk_in  = 1'b0;
    logic             reset   = 1'b1;
    logic             clk_div = 1'b0;
    logic [CNT_W-1:0] period_hc;
    logic [CNT_W-1:0] high_hc;
    logic             meas_valid;
    logic             locked;
    logic             err;
    logic [7:0]       err_count;

    freq_div_checker #(
        .DIV_N   (DIV_N),
        .LOCK_CNT(LOCK_CNT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .clk_div   (clk_div),
        .period_hc (period_hc),
        .high_hc   (high_hc),
        .meas_valid(meas_valid),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Half-cycle sample stream for the next run, and per-cycle captures
    bit          stim[$];
    logic [26:0] obs[$];
    logic [26:0] expq[$];
    logic [26:0] rst_obs;

    // Reference model: the stream since the last rise is kept as a list of
    // samples; a period is its length and the high time is its sum.
    bit m_meas;
    bit m_prev;
    bit seg[$];
    int m_good;
    bit m_locked;
    int m_errcnt;
    int m_period;
    int m_high;
    bit e_mv;
    bit e_err;

    function automatic logic [26:0] pack(input bit mv, input bit er, input bit lk,
                                         input int p, input int h, input int c);
        return {mv, er, lk, 8'(p), 8'(h), 8'(c)};
    endfunction

    function automatic logic [26:0] snap();
        return {meas_valid, err, locked, period_hc, high_hc, err_count};
    endfunction

    function automatic string fmt(input logic [26:0] v);
        return $sformatf("mv=%0b err=%0b lk=%0b per=%0d hi=%0d ec=%0d",
                         v[26], v[25], v[24], v[23:16], v[15:8], v[7:0]);
    endfunction

    function automatic void model_reset();
        m_meas   = 1'b0;
        m_prev   = 1'b0;
        seg.delete();
        m_good   = 0;
        m_locked = 1'b0;
        m_errcnt = 0;
        m_period = 0;
        m_high   = 0;
        e_mv     = 1'b0;
        e_err    = 1'b0;
    endfunction

    function automatic void model_pair(input bit a, input bit b);
        bit smp[2];
        bit rise_seen;
        int ones;
        smp       = '{a, b};
        rise_seen = 1'b0;
        e_mv      = 1'b0;
        e_err     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!m_prev && smp[i]) begin
                rise_seen = 1'b1;
                if (m_meas) begin
                    ones = 0;
                    foreach (seg[j]) ones += int'(seg[j]);
                    m_period = seg.size();
                    m_high   = ones;
                    e_mv     = 1'b1;
                    if (m_period == 2 * DIV_N && m_high == DIV_N) begin
                        m_good++;
                        if (m_good >= LOCK_CNT) m_locked = 1'b1;
                    end else begin
                        m_good   = 0;
                        m_locked = 1'b0;
                        e_err    = 1'b1;
                    end
                end
                seg.delete();
                m_meas = 1'b1;
            end
            if (m_meas) seg.push_back(smp[i]);
            m_prev = smp[i];
        end
        if (m_meas && !rise_seen && seg.size() >= 4 * DIV_N) begin
            e_err    = 1'b1;
            m_good   = 0;
            m_locked = 1'b0;
            m_meas   = 1'b0;
            seg.delete();
        end
        if (e_err && m_errcnt < 255) m_errcnt++;
    endfunction

    function automatic void push_pat(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < hi; i++) stim.push_back(1'b1);
            for (int i = 0; i < lo; i++) stim.push_back(1'b0);
        end
    endfunction

    function automatic void push_const(input bit v, input int n);
        for (int i = 0; i < n; i++) stim.push_back(v);
    endfunction

    // Drives stim two half-cycles per clk_in cycle and records, after each
    // rising edge, the DUT outputs next to the model state for the pair
    // processed one edge earlier. Entered and left 1 time unit after a
    // rising edge.
    task automatic run_stream();
        obs.delete();
        expq.delete();
        if (stim.size() % 2 != 0) stim.push_back(stim[stim.size() - 1]);
        for (int p = 0; p < stim.size() / 2; p++) begin
            clk_div = stim[2 * p];
            @(negedge clk_in);
            #1 clk_div = stim[2 * p + 1];
            @(posedge clk_in);
            #1;
            obs.push_back(snap());
            expq.push_back(pack(e_mv, e_err, m_locked, m_period, m_high, m_errcnt));
            model_pair(stim[2 * p], stim[2 * p + 1]);
        end
        stim.delete();
    endtask

    task automatic reset_dut();
        reset   = 1'b1;
        clk_div = 1'b1;
        @(posedge clk_in);
        #1 rst_obs = snap();
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge clk_in);
        #1;
        reset_dut();
        checks++;
        if (rst_obs !== 27'd0) begin
            errors++;
            $display("FAIL reset_state: got %s, want all zero", fmt(rst_obs));
        end
    endtask

    task automatic test_ideal();
        int first_lk;
        int mv_seen;
        push_const(1'b0, 4);
        push_pat(DIV_N, DIV_N, 8);
        run_stream();
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL ideal_stream[%0d]: got %s, want %s", i, fmt(obs[i]), fmt(expq[i]));
            end
        end
        first_lk = -1;
        mv_seen  = 0;
        foreach (obs[i]) begin
            if (first_lk < 0) begin
                if (obs[i][26]) mv_seen++;
                if (obs[i][24]) first_lk = i;
            end
        end
        checks++;
        if (first_lk < 0 || mv_seen != LOCK_CNT) begin
            errors++;
            $display("FAIL ideal_lock_point: got lock at meas_valid #%0d (cycle %0d), want #%0d", mv_seen, first_lk, LOCK_CNT);
        end
        checks++;
        if (period_hc !== 8'd6 || high_hc !== 8'd3 || locked !== 1'b1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL ideal_final: got per=%0d hi=%0d lk=%0b ec=%0d, want per=6 hi=3 lk=1 ec=0", period_hc, high_hc, locked, err_count);
        end
    endtask

    task automatic test_timeout();
        int n_err;
        push_pat(DIV_N, DIV_N, 3);
        push_const(1'b0, 30);
        run_stream();
        n_err = 0;
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL timeout_stream[%0d]: got %s, want %s", i, fmt(obs[i]), fmt(expq[i]));
            end
            if (obs[i][25]) n_err++;
        end
        checks++;
        if (n_err != 1 || locked !== 1'b0 || err_count !== 8'd1 || period_hc !== 8'd6) begin
            errors++;
            $display("FAIL timeout_once: got err pulses=%0d lk=%0b ec=%0d per=%0d, want 1 0 1 6", n_err, locked, err_count, period_hc);
        end
    endtask

    task automatic test_stretch();
        bit hit;
        push_pat(DIV_N, DIV_N, 6);
        push_pat(DIV_N, DIV_N + 2, 1);
        push_pat(DIV_N, DIV_N, 6);
        run_stream();
        hit = 1'b0;
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL stretch_stream[%0d]: got %s, want %s", i, fmt(obs[i]), fmt(expq[i]));
            end
            if (obs[i][26] && obs[i][25] && obs[i][23:16] == 8'd8 && !obs[i][24]) hit = 1'b1;
        end
        checks++;
        if (!hit || locked !== 1'b1) begin
            errors++;
            $display("FAIL stretch_relock: got per8_err_seen=%0b lk=%0b, want 1 1", hit, locked);
        end
    endtask

    task automatic test_posedge_div();
        int ec_before;
        ec_before = int'(err_count);
        push_pat(DIV_N + 1, DIV_N - 1, 8);
        run_stream();
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL posdiv_stream[%0d]: got %s, want %s", i, fmt(obs[i]), fmt(expq[i]));
            end
        end
        checks++;
        if (period_hc !== 8'd6 || high_hc !== 8'd4 || locked !== 1'b0 || int'(err_count) - ec_before != 7) begin
            errors++;
            $display("FAIL posdiv_final: got per=%0d hi=%0d lk=%0b ec_delta=%0d, want 6 4 0 7", period_hc, high_hc, locked, int'(err_count) - ec_before);
        end
    endtask

    task automatic test_reset_mid();
        int first_mv;
        push_pat(DIV_N, DIV_N, 6);
        push_const(1'b1, 2);
        run_stream();
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL resetmid_pre[%0d]: got %s, want %s", i, fmt(obs[i]), fmt(expq[i]));
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_locked_before: got lk=%0b, want 1", locked);
        end
        reset_dut();
        checks++;
        if (rst_obs !== 27'd0) begin
            errors++;
            $display("FAIL resetmid_outputs: got %s, want all zero", fmt(rst_obs));
        end
        push_pat(DIV_N, DIV_N, 6);
        run_stream();
        first_mv = -1;
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL resetmid_post[%0d]: got %s, want %s", i, fmt(obs[i]), fmt(expq[i]));
            end
            if (first_mv < 0 && obs[i][26]) first_mv = i;
        end
        // Rises at samples 0 and 6 fall in pairs 0 and 3; pair 3 shows at capture 4.
        checks++;
        if (first_mv != 4) begin
            errors++;
            $display("FAIL resetmid_first_meas: got capture %0d, want 4", first_mv);
        end
    endtask

    task automatic test_random();
        int hi;
        int lo;
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                hi = DIV_N;
                lo = DIV_N;
            end else begin
                hi = $urandom_range(1, 8);
                lo = $urandom_range(1, 14);
            end
            push_pat(hi, lo, 1);
        end
        push_const(1'b0, 2);
        run_stream();
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL random_stream[%0d]: got %s, want %s", i, fmt(obs[i]), fmt(expq[i]));
            end
        end
    endtask

    task automatic test_err_saturation();
        reset_dut();
        push_pat(1, 1, 270);
        run_stream();
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL errsat_stream[%0d]: got %s, want %s", i, fmt(obs[i]), fmt(expq[i]));
            end
        end
        checks++;
        if (err_count !== 8'd255 || err !== 1'b1 || locked !== 1'b0 || period_hc !== 8'd2) begin
            errors++;
            $display("FAIL errsat_final: got ec=%0d err=%0b lk=%0b per=%0d, want 255 1 0 2", err_count, err, locked, period_hc);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ideal();
        test_timeout();
        test_stretch();
        test_posedge_div();
        test_reset_mid();
        test_random();
        test_err_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/freq_div_checker.md
FREQ_DIV_CHECKER -- requirements
Module: freq_div_checker

Interface
REQ-001: Parameter DIV_N, default 3, expected integer divide ratio of clk_div relative to clk_in (range 2..63).
REQ-002: Parameter LOCK_CNT, default 4, consecutive good periods required to assert locked (range 1..15).
REQ-003: Parameter CNT_W, default 8, width of period_hc and high_hc; SHALL satisfy 2^CNT_W > 4*DIV_N.
REQ-004: clk_in  input  1  reference clock; all state on posedge clk_in except the negedge sampler (REQ-009).
REQ-005: reset  input  1  synchronous, active-high; clock clk_in.
REQ-006: clk_div  input  1  divided clock under test, generated synchronously from clk_in; no synchronizer.
REQ-007: period_hc, high_hc  output  CNT_W  last completed period and high time, in clk_in half-cycles.
REQ-008: meas_valid  output  1  one-cycle pulse when period_hc/high_hc update.
REQ-009: locked  output  1  level, ratio and duty confirmed.
REQ-010: err  output  1  one-cycle pulse on a bad period or a timeout.
REQ-011: err_count  output  8  saturating count of err pulses.

Function
REQ-012: clk_div SHALL be sampled at every negedge (s_neg, pre-edge value) and every posedge (s_pos, pre-edge value), giving a half-cycle sample stream x[k].
REQ-013: Each posedge SHALL process one pair (s_neg, then s_pos) against prev (last s_pos); at most one rise per pair.
REQ-014: A rise SHALL be a 0->1 step in x: (prev=0,s_neg=1) or (s_neg=0,s_pos=1).
REQ-015: Period SHALL equal the number of stream samples from one rise sample up to, excluding, the next rise sample; high time SHALL equal the number of 1-samples in that interval.
REQ-016: FSM states: IDLE (wait for first rise, no counting), MEAS (counting); reset enters IDLE.
REQ-017: IDLE -> MEAS on a rise; counters restart at that rise sample.
REQ-018: In MEAS, on a rise: latch period/high into period_hc/high_hc, pulse meas_valid, restart counters at the rise sample; stay in MEAS.
REQ-019: A measurement SHALL be good iff period == 2*DIV_N and high == DIV_N; otherwise err pulses with meas_valid.
REQ-020: Good-run counter SHALL increment on each good measurement, clear on bad; locked SHALL assert when it reaches LOCK_CNT and stay asserted until a bad measurement or timeout.
REQ-021: Timeout: if the in-progress period reaches 4*DIV_N half-cycles without a rise, err SHALL pulse once, locked and good-run SHALL clear, FSM -> IDLE; period_hc/high_hc unchanged, no meas_valid.
REQ-022: Half-cycle counters SHALL never wrap (guaranteed by REQ-003 and REQ-021).
REQ-023: Outputs SHALL be registered; meas_valid/err assert on the posedge after the posedge processing the closing pair (1 cycle latency).
REQ-024: err_count SHALL increment per err pulse, saturating at 255.

Reset
REQ-025: While reset is high at a posedge: FSM=IDLE, all counters 0, period_hc=0, high_hc=0, meas_valid=0, locked=0, err=0, err_count=0, prev=0.
REQ-026: Negedge sampler SHALL clear to 0 at a negedge with reset high; a rise in progress at reset assertion SHALL be discarded (no meas_valid, no err).

Verification
REQ-027: DIV_N=3, ideal 50% divide-by-3 on clk_div -> meas_valid every 3 cycles after the first rise, period_hc=6, high_hc=3, err never; locked after 4th meas_valid.
REQ-028: DIV_N=3, posedge-only divide-by-3 (high 2 cycles) -> period_hc=6, high_hc=4, err with every meas_valid, locked stays 0, err_count increments.
REQ-029: Locked stream, then clk_div held low -> err pulse once when 12 half-cycles pass without a rise, locked=0, FSM IDLE, no further err.
REQ-030: Locked stream, one period stretched to 8 half-cycles -> that measurement period_hc=8, err, locked drops; locked returns after 4 more good periods.
REQ-031: Reset asserted mid-period while locked -> next posedge all outputs 0; after release, first meas_valid only after two rises.
REQ-032: Force 260 errors -> err_count saturates at 255.
